// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / scoreboard slice.
//   XLEN_DEF, NREGS_DEF, AW_DEF : default geometry
//   ZERO_ADDR                   : architectural zero register
//   PORT_VEC_W                  : width that packed port-address vectors are
//                                 zero-extended to before calling f_port_addr
//   f_port_addr(vec, p, aw)     : extract field p (aw bits wide) from a packed
//                                 address vector
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int AW_DEF     = $clog2(NREGS_DEF);
  localparam int ZERO_ADDR  = 0;
  localparam int PORT_VEC_W = 128;

  // Returns the result right-aligned in 32 bits; callers narrow it with a
  // cast to their own address width.
  function automatic logic [31:0] f_port_addr(
    input logic [PORT_VEC_W-1:0] vec,
    input int unsigned           p,
    input int unsigned           aw = AW_DEF
  );
    return 32'(vec >> (p * aw)) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero register / same-cycle write bypass /
// stored value selection.
//   rst          : async active-low reset, forces outputs to 0 while low
//   rd_addr      : register being read
//   stored_data  : current contents of rd_addr
//   stored_busy  : current scoreboard bit of rd_addr
//   wr_en/wr_addr/wr_data : this cycle's write ports (packed)
//   rd_data      : read data
//   rd_busy      : busy flag seen by the reader
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr,
  input  logic [XLEN-1:0]   stored_data,
  input  logic              stored_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_busy
);

  logic [PORT_VEC_W-1:0] wr_addr_ext;

  assign wr_addr_ext = PORT_VEC_W'(wr_addr);

  always_comb begin
    logic [AW-1:0] wa;
    rd_data = stored_data;
    rd_busy = stored_busy;
    wa      = '0;
    // Ascending scan so the highest matching write port wins. A matching
    // write means the producer has arrived, so the reader sees not-busy.
    if (BYPASS != 0) begin
      for (int unsigned w = 0; w < NWR; w++) begin
        wa = AW'(f_port_addr(wr_addr_ext, w, AW));
        if (wr_en[w] && (wa == rd_addr)) begin
          rd_data = wr_data[w*XLEN +: XLEN];
          rd_busy = 1'b0;
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == AW'(ZERO_ADDR))) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
    // Storage is already cleared under reset; this also masks the bypass path.
    if (!rst) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register busy scoreboard.
//   clk, rst   : clock (rising edge), async active-low reset
//   rd_addr    : NRD packed read addresses
//   rd_data    : NRD packed read data (combinational)
//   rd_busy    : per-read-port busy flag (combinational)
//   wr_en/wr_addr/wr_data : NWR write ports, higher index wins on collision
//   alloc_en/alloc_addr   : mark a destination busy at issue
//   flush      : clear every busy bit (writes still land)
//   any_busy   : OR of the registered busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic                any_busy
);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [PORT_VEC_W-1:0] rd_addr_ext;
  logic [PORT_VEC_W-1:0] wr_addr_ext;

  assign rd_addr_ext = PORT_VEC_W'(rd_addr);
  assign wr_addr_ext = PORT_VEC_W'(wr_addr);

  always_comb begin
    logic [AW-1:0] wa;
    regs_d = regs_q;
    busy_d = busy_q;
    wa     = '0;
    // Ascending port order: a later port overwrites an earlier one.
    for (int unsigned w = 0; w < NWR; w++) begin
      wa = AW'(f_port_addr(wr_addr_ext, w, AW));
      if (wr_en[w]) begin
        if (!((ZERO_REG != 0) && (wa == AW'(ZERO_ADDR)))) begin
          regs_d[wa] = wr_data[w*XLEN +: XLEN];
        end
        busy_d[wa] = 1'b0;
      end
    end
    // A same-cycle allocation supersedes the completing write.
    if (alloc_en && !((ZERO_REG != 0) && (alloc_addr == AW'(ZERO_ADDR)))) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;

    assign ra = AW'(f_port_addr(rd_addr_ext, p, AW));

    regfile_rd_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rst         (rst),
      .rd_addr     (ra),
      .stored_data (regs_q[ra]),
      .stored_busy (busy_q[ra]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data[p*XLEN +: XLEN]),
      .rd_busy     (rd_busy[p])
    );
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor's single-write, dual-read register file, sized for the pipelined core.
- Multiple read and write ports; x0 hard-wired to zero.
- Optional write-to-read bypass in the same cycle.
- Per-register busy scoreboard: the decode stage allocates a destination, and writeback clears it.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; derived, do not override.
- NRD, 2, number of read ports, 1 to 4.
- NWR, 2, number of write ports, 1 to 2.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored values only.
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port p occupies bits [p*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  busy flag for each read port, combinational.
- wr_en  in  NWR  write enable for each write port.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.
- alloc_en  in  1  mark alloc_addr busy (an instruction with that destination has been issued).
- alloc_addr  in  AW  register to mark busy.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits, registered-state based.

Behaviour:
- Reset is asynchronous on rst low: all registers are 0 and all busy bits are 0. While rst is low, rd_data is 0, rd_busy is 0 and any_busy is 0.
- Register writes:
  - On the clk rising edge, each port w with wr_en[w]=1 writes wr_data[w] to wr_addr[w].
  - If two ports target the same address in one cycle, the higher port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational, with zero cycles of latency.
  - ZERO_REG=1 and address 0: data is 0 and busy is 0.
  - BYPASS=1 and some wr_en[w] has wr_addr[w] equal to the read address: data is wr_data of the highest matching w, and rd_busy is 0.
  - Otherwise: data is the stored value, and rd_busy is the stored busy bit.
- Scoreboard, next state of busy[r] for each register, in priority order:
  1. flush=1: 0 for every r. Register writes in the same cycle still complete.
  2. alloc_en=1 and alloc_addr=r: 1. Allocation beats a same-cycle write to r, because the new producer supersedes the old one.
  3. Any wr_en[w] with wr_addr[w]=r: 0.
  4. Otherwise: hold.
- Allocation to address 0 with ZERO_REG=1 is ignored.
- Re-allocating a register that is already busy keeps it busy; there is no error and no count.
- A write to a register that is not busy is legal and leaves it not busy.
- any_busy is the OR of the registered busy bits; it does not reflect same-cycle alloc or write.
- Out-of-range addresses are unreachable because NREGS is a power of two.
- Reset asserted mid-operation overrides any in-flight write or alloc immediately.

Decomposition:
- Shared package regfile_pkg holds:
  - the default XLEN, NREGS and AW;
  - the function f_port_addr(vec, p) that extracts packed port fields;
  - the localparam ZERO_ADDR = 0.
- One sub-module, regfile_rd_port, is natural: it implements the zero / bypass / stored mux for a single read port. Instantiate it NRD times via generate.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset: drive rst low while writing 0xDEADBEEF to x5, then release and read x5 → rd_data 0, rd_busy 0, any_busy 0.
- Write then read: write x3=0x12345678 on port 0; next cycle read x3 on port 1 → 0x12345678. Write x0=0xFFFFFFFF, then read x0 → 0.
- Bypass: with BYPASS=1, drive wr_en[1] for x7=0xA5A5A5A5 and read x7 in the same cycle → 0xA5A5A5A5 and rd_busy 0. Repeat with BYPASS=0 → old value 0.
- Write collision: port 0 writes x9=0x1111 and port 1 writes x9=0x2222 in the same cycle → x9 reads 0x2222 afterwards.
- Scoreboard: alloc x4, then read next cycle → rd_busy 1 and any_busy 1. Write x4=0x55 → busy 0 the following cycle. Alloc x4 and write x4 in the same cycle → busy 1 the following cycle.
- Flush: alloc x1, x2 and x31 on consecutive cycles, then pulse flush together with a write of x2=0x77 → all busy 0, any_busy 0, x2 reads 0x77.
